spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 186 ++++++++++++++++++
 tb/tb_spi_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: a single-slave SPI master. It supports all four CPOL/CPHA modes,
// a frame width set at elaboration time and a programmable sclk half-period.
// A frame runs SETUP (clk_div cycles), XFER (2*bits_num sclk edges), HOLD
// (clk_div cycles) and END (one cycle with the tx_end pulse), then returns to IDLE.
module spi_master #(
    parameter logic [1:0] mode     = 2'b00,
    parameter int         bits_num = 8,
    parameter int         clk_div  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [bits_num-1:0] data_in,
    input  logic                miso,
    output logic                ss,
    output logic                sclk,
    output logic                mosi,
    output logic                tx_end,
    output logic                busy,
    output logic [bits_num-1:0] data_out
);

    localparam logic CPOL = mode[1];
    localparam logic CPHA = mode[0];

    // The half-period counter wraps at clk_div-1.
    // The edge counter counts up to 2*bits_num.
    localparam int DIV_W  = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int EDGE_W = $clog2(2 * bits_num + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(clk_div - 1);
    localparam logic [EDGE_W-1:0] EDGE_TOTAL = EDGE_W'(2 * bits_num);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        END   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic [bits_num-1:0] r_tx_shift;
    logic [bits_num-1:0] r_rx_shift;
    logic [bits_num-1:0] r_data_out;
    logic                r_sclk;
    logic                r_mosi;

    logic                w_div_last;
    logic                w_edge_now;
    logic [EDGE_W-1:0]   w_edge_num;
    logic                w_leading;
    logic                w_last_edge;

    // w_edge_num is the number of the sclk edge produced by this clock, if any.
    assign w_div_last  = (r_div_cnt == DIV_LAST);
    assign w_edge_now  = (r_state == XFER) && w_div_last;
    assign w_edge_num  = r_edge_cnt + 1'b1;
    assign w_leading   = w_edge_num[0];
    assign w_last_edge = (w_edge_num == EDGE_TOTAL);

    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign data_out = r_data_out;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the state-decoded outputs (ss, busy, tx_end).
    always_comb begin
        w_state_next = r_state;
        ss           = 1'b1;
        busy         = 1'b1;
        tx_end       = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                ss = 1'b0;
                if (w_div_last) begin
                    w_state_next = XFER;
                end
            end
            XFER: begin
                ss = 1'b0;
                if (w_edge_now && w_last_edge) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                ss = 1'b0;
                if (w_div_last) begin
                    w_state_next = END;
                end
            end
            END: begin
                tx_end       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: counters, sclk generation, and the tx/rx shift registers.
    // The rx word is committed only on HOLD->END, so an aborted frame never updates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_data_out <= '0;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_div_cnt  <= '0;
                    r_edge_cnt <= '0;
                    r_sclk     <= CPOL;
                    if (start) begin
                        r_tx_shift <= data_in;
                        r_rx_shift <= '0;
                        r_mosi     <= data_in[bits_num-1];
                    end
                end
                SETUP: begin
                    r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
                end
                XFER: begin
                    r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
                    if (w_edge_now) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= w_edge_num;
                        if (!CPHA) begin
                            // Sample on the leading edge; advance mosi on non-final trailing edges.
                            if (w_leading) begin
                                r_rx_shift <= {r_rx_shift[bits_num-2:0], miso};
                            end else if (!w_last_edge) begin
                                r_tx_shift <= {r_tx_shift[bits_num-2:0], 1'b0};
                                r_mosi     <= r_tx_shift[bits_num-2];
                            end
                        end else begin
                            // Drive on the leading edge (edge 1 re-drives the MSB); sample on the trailing edge.
                            if (w_leading) begin
                                if (w_edge_num == EDGE_W'(1)) begin
                                    r_mosi <= r_tx_shift[bits_num-1];
                                end else begin
                                    r_tx_shift <= {r_tx_shift[bits_num-2:0], 1'b0};
                                    r_mosi     <= r_tx_shift[bits_num-2];
                                end
                            end else begin
                                r_rx_shift <= {r_rx_shift[bits_num-2:0], miso};
                            end
                        end
                    end
                end
                HOLD: begin
                    r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
                    if (w_div_last) begin
                        r_data_out <= r_rx_shift;
                    end
                end
                default: begin
                    r_div_cnt  <= '0;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master. u_m0 (mode 00, clk_div 2, 8 bits)
// talks to a behavioural mode-0 slave. u_m1..u_m3 cover the other modes in
// loopback, and u_w is the 16-bit, clk_div 1 loopback case.
module tb_spi_master;

    logic clk;
    logic reset;

    // u_m0 signals
    logic       start0;
    logic [7:0] data_in0;
    logic       miso0, ss0, sclk0, mosi0, tx_end0, busy0;
    logic [7:0] data_out0;

    // Loopback mode instances share start and data.
    logic       start_lb;
    logic [7:0] data_lb;
    logic       ss1, sclk1, mosi1, tx_end1, busy1;
    logic       ss2, sclk2, mosi2, tx_end2, busy2;
    logic       ss3, sclk3, mosi3, tx_end3, busy3;
    logic [7:0] data_out1, data_out2, data_out3;

    // Wide instance
    logic        start_w;
    logic [15:0] data_w;
    logic        ss_w, sclk_w, mosi_w, tx_end_w, busy_w;
    logic [15:0] data_out_w;

    int checks   = 0;
    int failures = 0;

    spi_master #(.mode(2'b00), .bits_num(8), .clk_div(2)) u_m0 (
        .clk(clk), .reset(reset), .start(start0), .data_in(data_in0), .miso(miso0),
        .ss(ss0), .sclk(sclk0), .mosi(mosi0), .tx_end(tx_end0), .busy(busy0), .data_out(data_out0));

    spi_master #(.mode(2'b01), .bits_num(8), .clk_div(2)) u_m1 (
        .clk(clk), .reset(reset), .start(start_lb), .data_in(data_lb), .miso(mosi1),
        .ss(ss1), .sclk(sclk1), .mosi(mosi1), .tx_end(tx_end1), .busy(busy1), .data_out(data_out1));

    spi_master #(.mode(2'b10), .bits_num(8), .clk_div(2)) u_m2 (
        .clk(clk), .reset(reset), .start(start_lb), .data_in(data_lb), .miso(mosi2),
        .ss(ss2), .sclk(sclk2), .mosi(mosi2), .tx_end(tx_end2), .busy(busy2), .data_out(data_out2));

    spi_master #(.mode(2'b11), .bits_num(8), .clk_div(2)) u_m3 (
        .clk(clk), .reset(reset), .start(start_lb), .data_in(data_lb), .miso(mosi3),
        .ss(ss3), .sclk(sclk3), .mosi(mosi3), .tx_end(tx_end3), .busy(busy3), .data_out(data_out3));

    spi_master #(.mode(2'b00), .bits_num(16), .clk_div(1)) u_w (
        .clk(clk), .reset(reset), .start(start_w), .data_in(data_w), .miso(mosi_w),
        .ss(ss_w), .sclk(sclk_w), .mosi(mosi_w), .tx_end(tx_end_w), .busy(busy_w), .data_out(data_out_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mode-0 slave: it shifts s_word out MSB first, changing miso on
    // falling sclk, and captures mosi on rising sclk.
    logic [7:0] s_word = 8'h00;
    logic [7:0] s_rx   = 8'h00;
    logic [7:0] s_cap [16];
    int         s_idx  = 7;
    int         s_rise = 0;
    int         s_ncap = 0;

    assign miso0 = (s_idx >= 0) ? s_word[s_idx[2:0]] : 1'b0;

    always @(posedge ss0 or negedge sclk0) begin
        if (ss0) s_idx = 7;
        else     s_idx = s_idx - 1;
    end

    always @(posedge sclk0) begin
        if (!ss0) begin
            s_rx   = {s_rx[6:0], mosi0};
            s_rise = s_rise + 1;
        end
    end

    always @(posedge ss0) begin
        if (s_ncap < 16) s_cap[s_ncap] = s_rx;
        s_ncap = s_ncap + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, edges, txc, pulses, gap, rise0, n0;
        logic prev;
        reset = 1'b1; start0 = 1'b1; data_in0 = 8'h00;
        start_lb = 1'b0; data_lb = 8'h00; start_w = 1'b0; data_w = 16'h0000;

        // Reset state; the start held high during reset must be dropped.
        tick(3);
        reset = 1'b0; start0 = 1'b0;
        chk("rst_ss", ss0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_tx_end", tx_end0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_data_out", data_out0, 0);
        chk("rst_sclk_cpol1", sclk2, 1);
        tick(1);
        chk("start_in_reset_ignored", busy0, 0);

        // Reset at the 5th sclk edge aborts the frame.
        s_word = 8'h3C; data_in0 = 8'hC3; start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        edges = 0; n = 0; prev = sclk0;
        while (edges < 5 && n < 100) begin
            tick(1); n++;
            if (sclk0 !== prev) edges++;
            prev = sclk0;
        end
        chk("abort_edges_seen", edges, 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_ss", ss0, 1);
        chk("abort_sclk", sclk0, 0);
        chk("abort_busy", busy0, 0);
        txc = 0;
        repeat (60) begin tick(1); txc += int'(tx_end0); end
        chk("abort_no_tx_end", txc, 0);
        chk("abort_data_out", data_out0, 0);

        // Mode 00, A5 out, slave returns 3C, tx_end 37 cycles after start.
        s_word = 8'h3C; data_in0 = 8'hA5; rise0 = s_rise; start0 = 1'b1;
        tick(1);
        start0 = 1'b0; data_in0 = 8'h00;
        chk("f1_ss_low", ss0, 0);
        chk("f1_busy", busy0, 1);
        chk("f1_mosi_msb", mosi0, 1);
        chk("f1_sclk_idle", sclk0, 0);
        n = 1;
        while (!tx_end0 && n < 200) begin tick(1); n++; end
        chk("f1_len", n, 37);
        chk("f1_tx_end", tx_end0, 1);
        chk("f1_end_ss", ss0, 1);
        chk("f1_end_busy", busy0, 1);
        chk("f1_data_out", data_out0, 8'h3C);
        chk("f1_slave_rx", s_rx, 8'hA5);
        chk("f1_rising_edges", s_rise - rise0, 8);
        tick(1);
        chk("f1_tx_end_pulse", tx_end0, 0);
        chk("f1_idle_busy", busy0, 0);
        chk("f1_data_held", data_out0, 8'h3C);

        // A start pulse during XFER is ignored.
        s_word = 8'hC3; data_in0 = 8'h5A; start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(10);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        txc = 0;
        repeat (100) begin tick(1); txc += int'(tx_end0); end
        chk("busy_start_one_tx_end", txc, 1);
        chk("busy_start_data_out", data_out0, 8'hC3);
        chk("busy_start_slave_rx", s_rx, 8'h5A);

        // Back-to-back FF then 00 with start held high.
        s_word = 8'h5A; n0 = s_ncap; data_in0 = 8'hFF; start0 = 1'b1;
        tick(1);
        data_in0 = 8'h00;
        pulses = 0; gap = 0; n = 0;
        while (pulses < 2 && n < 200) begin
            if (tx_end0) pulses++;
            if (pulses == 1 && ss0) gap++;
            if (pulses < 2) begin tick(1); n++; end
        end
        start0 = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_ss_gap", (gap >= 1), 1);
        chk("b2b_data_out", data_out0, 8'h5A);
        tick(3);
        chk("b2b_no_third", busy0, 0);
        chk("b2b_words", s_ncap - n0, 2);
        chk("b2b_word0", s_cap[n0 % 16], 8'hFF);
        chk("b2b_word1", s_cap[(n0 + 1) % 16], 8'h00);

        // Modes 01, 10, 11 in loopback with 81.
        chk("lb_pre_sclk1", sclk1, 0);
        chk("lb_pre_sclk2", sclk2, 1);
        chk("lb_pre_sclk3", sclk3, 1);
        data_lb = 8'h81; start_lb = 1'b1;
        tick(1);
        start_lb = 1'b0;
        n = 1;
        while (!tx_end1 && n < 200) begin tick(1); n++; end
        chk("lb_len", n, 37);
        chk("lb_data_out1", data_out1, 8'h81);
        chk("lb_data_out2", data_out2, 8'h81);
        chk("lb_data_out3", data_out3, 8'h81);
        tick(1);
        chk("lb_post_sclk1", sclk1, 0);
        chk("lb_post_sclk2", sclk2, 1);
        chk("lb_post_sclk3", sclk3, 1);

        // 16-bit, clk_div 1, BEEF loopback, 35-cycle frame.
        data_w = 16'hBEEF; start_w = 1'b1;
        tick(1);
        start_w = 1'b0;
        n = 1;
        while (!tx_end_w && n < 200) begin tick(1); n++; end
        chk("w_len", n, 35);
        chk("w_data_out", data_out_w, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
